// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage: ALU opcodes, forward-select
// codes and the bundle of downstream control bits carried through the stage.
package alu_operand_stage_pkg;

   typedef logic [3:0] alu_op_t;
   typedef logic [1:0] fwd_sel_t;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_NOR = 4'b0010;
   localparam alu_op_t ALU_ADD = 4'b0011;
   localparam alu_op_t ALU_SLL = 4'b0100;
   localparam alu_op_t ALU_SRL = 4'b0101;
   localparam alu_op_t ALU_ORI = 4'b0111;
   localparam alu_op_t ALU_LUI = 4'b1000;
   localparam alu_op_t ALU_SUB = 4'b1001;

   localparam fwd_sel_t FWD_HELD  = 2'b00;
   localparam fwd_sel_t FWD_EXMEM = 2'b01;
   localparam fwd_sel_t FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ctrl_t;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB beats the held register value.
// Register 0 is hard-wired and never forwarded.
module alu_operand_stage_fwd_select
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] held_addr_i,
   input  logic [DATA_W-1:0] held_data_i,
   input  logic              exmem_reg_write_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [DATA_W-1:0] exmem_result_i,
   input  logic              memwb_reg_write_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [DATA_W-1:0] memwb_result_i,
   output logic [DATA_W-1:0] fwd_data_o,
   output fwd_sel_t          fwd_sel_o
);

   logic exmem_hit;
   logic memwb_hit;

   assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == held_addr_i);
   assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == held_addr_i);

   always_comb begin
      fwd_sel_o  = FWD_HELD;
      fwd_data_o = held_data_i;
      if (exmem_hit) begin
         fwd_sel_o  = FWD_EXMEM;
         fwd_data_o = exmem_result_i;
      end else if (memwb_hit) begin
         fwd_sel_o  = FWD_MEMWB;
         fwd_data_o = memwb_result_i;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Drives A, B, ALUOperation and Shamt of the downstream 32-bit ALU.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_shamt,
   input  logic [3:0]        id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_uses_rt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              load_use,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_alu_a,
   output logic [DATA_W-1:0] ex_alu_b,
   output logic [3:0]        ex_alu_op,
   output logic [4:0]        ex_shamt,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);

   logic              valid_q, valid_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
   logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [4:0]        shamt_q, shamt_d;
   alu_op_t           alu_op_q, alu_op_d;
   logic              alu_src_q, alu_src_d;

   logic              bubble;
   logic [DATA_W-1:0] fwd_rs_data, fwd_rt_data;
   fwd_sel_t          fwd_rs_sel, fwd_rt_sel;

   function automatic logic wb_match(input logic [REG_AW-1:0] addr);
      return memwb_reg_write && (memwb_rd != '0) && (memwb_rd == addr);
   endfunction

   assign load_use = valid_q && ctrl_q.mem_read && (dest_q != '0) &&
                     ((dest_q == id_rs_addr) || (id_uses_rt && (dest_q == id_rt_addr)));

   // Flush always wins; a load-use bubble only goes in when the stage is free to advance.
   assign bubble = flush || (!stall && load_use);

   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      dest_d    = dest_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      shamt_d   = shamt_q;
      alu_op_d  = alu_op_q;
      alu_src_d = alu_src_q;
      if (bubble) begin
         valid_d   = 1'b0;
         ctrl_d    = '0;
         rs_addr_d = '0;
         rt_addr_d = '0;
         dest_d    = '0;
         rs_data_d = '0;
         rt_data_d = '0;
         imm_d     = '0;
         shamt_d   = '0;
         alu_op_d  = '0;
         alu_src_d = 1'b0;
      end else if (stall) begin
         // Keep held operands current so a long stall does not lose a retiring write.
         if (wb_match(rs_addr_q)) rs_data_d = memwb_result;
         if (wb_match(rt_addr_q)) rt_data_d = memwb_result;
      end else begin
         valid_d   = id_valid;
         ctrl_d    = '{reg_write:  id_reg_write  & id_valid,
                       mem_read:   id_mem_read   & id_valid,
                       mem_write:  id_mem_write  & id_valid,
                       mem_to_reg: id_mem_to_reg & id_valid};
         rs_addr_d = id_rs_addr;
         rt_addr_d = id_rt_addr;
         dest_d    = id_rd_addr;
         rs_data_d = wb_match(id_rs_addr) ? memwb_result : id_rs_data;
         rt_data_d = wb_match(id_rt_addr) ? memwb_result : id_rt_data;
         imm_d     = id_imm;
         shamt_d   = id_shamt;
         alu_op_d  = id_alu_op;
         alu_src_d = id_alu_src;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         dest_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         alu_op_q  <= '0;
         alu_src_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         dest_q    <= dest_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         shamt_q   <= shamt_d;
         alu_op_q  <= alu_op_d;
         alu_src_q <= alu_src_d;
      end
   end

   alu_operand_stage_fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rs (
      .held_addr_i       (rs_addr_q),
      .held_data_i       (rs_data_q),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .exmem_result_i    (exmem_result),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_result_i    (memwb_result),
      .fwd_data_o        (fwd_rs_data),
      .fwd_sel_o         (fwd_rs_sel)
   );

   alu_operand_stage_fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rt (
      .held_addr_i       (rt_addr_q),
      .held_data_i       (rt_data_q),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .exmem_result_i    (exmem_result),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_result_i    (memwb_result),
      .fwd_data_o        (fwd_rt_data),
      .fwd_sel_o         (fwd_rt_sel)
   );

   assert property (@(posedge clk) disable iff (reset)
                    (fwd_rs_sel != 2'b11) && (fwd_rt_sel != 2'b11));

   assign ex_valid      = valid_q;
   assign ex_alu_a      = fwd_rs_data;
   assign ex_store_data = fwd_rt_data;
   assign ex_alu_b      = alu_src_q ? imm_q : fwd_rt_data;
   assign ex_alu_op     = alu_op_q;
   assign ex_shamt      = shamt_q;
   assign ex_dest       = dest_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        id_valid, id_alu_src, id_uses_rt;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_alu_op;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use, ex_valid;
   logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_shamt, ex_dest;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

   always #5 clk = ~clk;

   alu_operand_stage #(
      .DATA_W (32),
      .REG_AW (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_rs_addr      (id_rs_addr),
      .id_rt_addr      (id_rt_addr),
      .id_rd_addr      (id_rd_addr),
      .id_rs_data      (id_rs_data),
      .id_rt_data      (id_rt_data),
      .id_imm          (id_imm),
      .id_shamt        (id_shamt),
      .id_alu_op       (id_alu_op),
      .id_alu_src      (id_alu_src),
      .id_uses_rt      (id_uses_rt),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .id_mem_write    (id_mem_write),
      .id_mem_to_reg   (id_mem_to_reg),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .load_use        (load_use),
      .ex_valid        (ex_valid),
      .ex_alu_a        (ex_alu_a),
      .ex_alu_b        (ex_alu_b),
      .ex_alu_op       (ex_alu_op),
      .ex_shamt        (ex_shamt),
      .ex_store_data   (ex_store_data),
      .ex_dest         (ex_dest),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read),
      .ex_mem_write    (ex_mem_write),
      .ex_mem_to_reg   (ex_mem_to_reg)
   );

   typedef enum int {FldValid, FldA, FldB, FldStore, FldLoadUse, FldRegWrite, FldMemRead,
                     FldMemWrite, FldOp, FldDest, FldShamt} fld_e;

   typedef struct {
      fld_e        fld;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] sample(input fld_e f);
      case (f)
         FldValid:    return {31'd0, ex_valid};
         FldA:        return ex_alu_a;
         FldB:        return ex_alu_b;
         FldStore:    return ex_store_data;
         FldLoadUse:  return {31'd0, load_use};
         FldRegWrite: return {31'd0, ex_reg_write};
         FldMemRead:  return {31'd0, ex_mem_read};
         FldMemWrite: return {31'd0, ex_mem_write};
         FldOp:       return {28'd0, ex_alu_op};
         FldDest:     return {27'd0, ex_dest};
         FldShamt:    return {27'd0, ex_shamt};
         default:     return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Expectations pushed during a cycle are due at that cycle's falling edge.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = sample(e.fld);
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
         end
      end
   end

   task automatic push(input fld_e f, input logic [31:0] v, input string n);
      exp_t e;
      e.fld  = f;
      e.val  = v;
      e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [4:0] sh, input logic [3:0] op, input logic src,
                           input logic urt, input logic rw, input logic mr, input logic mw,
                           input logic m2r);
      id_valid      = v;
      id_rs_addr    = rs;
      id_rt_addr    = rt;
      id_rd_addr    = rd;
      id_rs_data    = rsd;
      id_rt_data    = rtd;
      id_imm        = imm;
      id_shamt      = sh;
      id_alu_op     = op;
      id_alu_src    = src;
      id_uses_rt    = urt;
      id_reg_write  = rw;
      id_mem_read   = mr;
      id_mem_write  = mw;
      id_mem_to_reg = m2r;
   endtask

   task automatic idle_id();
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fwd_off();
      exmem_reg_write = 1'b0;
      exmem_rd        = 5'd0;
      exmem_result    = 32'd0;
      memwb_reg_write = 1'b0;
      memwb_rd        = 5'd0;
      memwb_result    = 32'd0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      idle_id();
      fwd_off();
      tick();
      tick();
      push(FldValid, 0, "rst_valid");
      push(FldA, 0, "rst_alu_a");
      push(FldB, 0, "rst_alu_b");
      push(FldOp, 0, "rst_alu_op");
      push(FldLoadUse, 0, "rst_load_use");
      push(FldRegWrite, 0, "rst_reg_write");
      tick();
      reset = 1'b0;

      // add r10 = r8 + r3, then hold it while forwarding sources change
      drive_id(1, 5'd8, 5'd3, 5'd10, 32'd5, 32'd7, 32'd0, 5'd7, ALU_ADD, 0, 1, 1, 0, 0, 0);
      tick();
      idle_id();
      stall = 1'b1;
      push(FldValid, 1, "cap_valid");
      push(FldA, 5, "cap_alu_a");
      push(FldB, 7, "cap_alu_b");
      push(FldDest, 10, "cap_dest");
      push(FldOp, 32'(ALU_ADD), "cap_alu_op");
      push(FldShamt, 7, "cap_shamt");
      push(FldRegWrite, 1, "cap_reg_write");
      tick();
      exmem_reg_write = 1'b1;
      exmem_rd        = 5'd8;
      exmem_result    = 32'h1234;
      push(FldA, 32'h1234, "exmem_fwd_a");
      push(FldStore, 7, "rt_not_fwd");
      tick();
      memwb_reg_write = 1'b1;
      memwb_rd        = 5'd8;
      memwb_result    = 32'h9;
      push(FldA, 32'h1234, "exmem_beats_memwb");
      tick();
      fwd_off();
      push(FldA, 32'h9, "rs_wb_refresh");
      memwb_reg_write = 1'b1;
      memwb_rd        = 5'd3;
      memwb_result    = 32'h77;
      push(FldStore, 32'h77, "memwb_fwd_store");
      push(FldB, 32'h77, "memwb_fwd_b");
      tick();
      stall = 1'b0;
      fwd_off();
      push(FldStore, 32'h77, "rt_wb_refresh");
      push(FldValid, 1, "stall_held_valid");
      tick();

      // register zero: load with dest 0 and an EX/MEM write to r0
      drive_id(1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, ALU_ADD, 0, 0, 0, 1, 0, 1);
      tick();
      idle_id();
      exmem_reg_write = 1'b1;
      exmem_rd        = 5'd0;
      exmem_result    = 32'hFFFF;
      push(FldA, 0, "r0_no_fwd");
      push(FldLoadUse, 0, "r0_no_load_use");
      push(FldMemRead, 1, "r0_mem_read");
      tick();
      fwd_off();
      drive_id(0, 5'd1, 5'd2, 5'd3, 32'h44, 32'h55, 32'd0, 5'd0, ALU_ADD, 0, 1, 1, 1, 1, 1);
      tick();
      push(FldValid, 0, "inv_valid");
      push(FldRegWrite, 0, "inv_reg_write");
      push(FldMemRead, 0, "inv_mem_read");
      push(FldMemWrite, 0, "inv_mem_write");

      // lw r9, 4(r2) followed by add r11 = r9 + r4
      drive_id(1, 5'd2, 5'd9, 5'd9, 32'h100, 32'd0, 32'd4, 5'd0, ALU_ADD, 1, 0, 1, 1, 0, 1);
      tick();
      drive_id(1, 5'd9, 5'd4, 5'd11, 32'hAA, 32'h10, 32'd0, 5'd0, ALU_ADD, 0, 1, 1, 0, 0, 0);
      push(FldLoadUse, 1, "lu_rs");
      push(FldA, 32'h100, "lw_alu_a");
      push(FldB, 4, "lw_imm_b");
      tick();
      push(FldValid, 0, "lu_bubble_valid");
      push(FldRegWrite, 0, "lu_bubble_reg_write");
      push(FldLoadUse, 0, "lu_cleared");
      memwb_reg_write = 1'b1;
      memwb_rd        = 5'd9;
      memwb_result    = 32'h55;
      tick();
      fwd_off();
      push(FldValid, 1, "lu_add_valid");
      push(FldDest, 11, "lu_add_dest");
      push(FldA, 32'h55, "wb_bypass_rs");
      push(FldB, 32'h10, "lu_add_b");
      push(FldLoadUse, 0, "lu_after_capture");

      // load-use through rt only counts when the instruction reads rt
      drive_id(1, 5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 5'd0, ALU_ADD, 1, 0, 1, 1, 0, 1);
      tick();
      drive_id(1, 5'd7, 5'd6, 5'd12, 32'd0, 32'd0, 32'd0, 5'd0, ALU_ADD, 0, 0, 1, 0, 0, 0);
      stall = 1'b1;
      push(FldLoadUse, 0, "lu_rt_unused");
      tick();
      id_uses_rt = 1'b1;
      push(FldLoadUse, 1, "lu_rt");
      tick();
      stall = 1'b0;
      idle_id();
      tick();

      // LUI-style op with immediate B; rt=4 refreshed by write-back during a 3-cycle stall
      drive_id(1, 5'd5, 5'd4, 5'd0, 32'h20, 32'h1111, 32'h0000BEEF, 5'd0, ALU_LUI,
               1, 0, 0, 0, 1, 0);
      tick();
      idle_id();
      stall = 1'b1;
      push(FldStore, 32'h1111, "st_held");
      push(FldB, 32'h0000BEEF, "lui_imm_b");
      push(FldMemWrite, 1, "st_mem_write");
      push(FldOp, 32'(ALU_LUI), "lui_alu_op");
      tick();
      memwb_reg_write = 1'b1;
      memwb_rd        = 5'd4;
      memwb_result    = 32'hABCD;
      push(FldStore, 32'hABCD, "st_memwb_fwd");
      tick();
      fwd_off();
      push(FldStore, 32'hABCD, "st_refresh_in_stall");
      tick();
      stall = 1'b0;
      push(FldStore, 32'hABCD, "st_after_stall");
      push(FldB, 32'h0000BEEF, "lui_b_after_stall");
      push(FldValid, 1, "lui_valid_after_stall");
      tick();
      push(FldValid, 0, "idle_capture");

      // flush and stall together
      drive_id(1, 5'd1, 5'd2, 5'd13, 32'h10, 32'h20, 32'd0, 5'd0, ALU_OR, 0, 1, 1, 0, 0, 0);
      tick();
      idle_id();
      push(FldValid, 1, "pre_flush_valid");
      flush = 1'b1;
      stall = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      push(FldValid, 0, "flush_valid");
      push(FldRegWrite, 0, "flush_reg_write");
      push(FldA, 0, "flush_alu_a");
      push(FldDest, 0, "flush_dest");

      // asynchronous reset right after a valid instruction is captured
      drive_id(1, 5'd3, 5'd0, 5'd14, 32'h33, 32'd0, 32'd0, 5'd0, ALU_SUB, 0, 0, 1, 0, 0, 0);
      tick();
      reset = 1'b1;
      idle_id();
      push(FldValid, 0, "async_rst_valid");
      push(FldA, 0, "async_rst_alu_a");
      push(FldRegWrite, 0, "async_rst_reg_write");
      push(FldOp, 0, "async_rst_alu_op");
      push(FldDest, 0, "async_rst_dest");
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();

      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
